// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory request/response and decode handoff.
// Master side is the fetch unit; slave side is memory plus decode.
interface if_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        output id_valid,
        output id_pc,
        output id_inst,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        input  id_valid,
        input  id_pc,
        input  id_inst,
        output id_ready
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Decoupled fetch front end: in-order imem handshake feeding a fetch queue.
// Redirects flush the queue and count stale in-flight responses to drop.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_br_mispred,
    input  logic [31:0] ex_alu,
    input  logic        id_target_taken,
    input  logic [31:0] id_target,
    if_fetch_unit_if.master fq
);
    localparam int AW = $clog2(FQ_DEPTH);
    localparam int PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   sum_t;

    localparam ptr_t ONE  = ptr_t'(1);
    localparam ptr_t FULL = ptr_t'(FQ_DEPTH);

    logic [31:0]         fetch_pc;
    logic [31:0]         slot_pc   [FQ_DEPTH];
    logic [31:0]         slot_inst [FQ_DEPTH];
    logic [FQ_DEPTH-1:0] slot_filled;

    // Pointers carry one wrap bit so full and empty stay distinguishable.
    ptr_t alloc_ptr;
    ptr_t fill_ptr;
    ptr_t head_ptr;
    ptr_t drop;

    ptr_t count;
    ptr_t unfilled;
    ptr_t count_eff;
    ptr_t unfilled_eff;
    ptr_t drop_eff;
    sum_t inflight_eff;

    logic          redirect;
    logic [31:0]   target;
    logic          req_fire;
    logic          deq_fire;
    logic          resp_fill;
    logic [AW-1:0] alloc_idx;
    logic [AW-1:0] fill_idx;
    logic [AW-1:0] head_idx;

    assign redirect = ex_br_mispred | id_target_taken;
    assign target   = ex_br_mispred ? ex_alu : id_target;

    assign count    = alloc_ptr - head_ptr;
    assign unfilled = alloc_ptr - fill_ptr;

    assign alloc_idx = alloc_ptr[AW-1:0];
    assign fill_idx  = fill_ptr[AW-1:0];
    assign head_idx  = head_ptr[AW-1:0];

    always_comb begin
        count_eff    = count;
        unfilled_eff = unfilled;
        drop_eff     = drop;
        if (redirect) begin
            count_eff    = '0;
            unfilled_eff = '0;
            drop_eff     = drop + unfilled
                         - ptr_t'(fq.imem_resp_valid);
        end
    end

    assign inflight_eff = {1'b0, drop_eff}
                        + {1'b0, unfilled_eff};

    assign fq.imem_req_valid = rst
                             & (count_eff < FULL)
                             & (inflight_eff < sum_t'(FQ_DEPTH));
    assign fq.imem_req_addr  = redirect ? target : fetch_pc;

    assign fq.id_valid = (count != '0)
                       & slot_filled[head_idx]
                       & ~redirect;
    assign fq.id_pc    = fq.id_valid ? slot_pc[head_idx]   : '0;
    assign fq.id_inst  = fq.id_valid ? slot_inst[head_idx] : '0;

    assign req_fire  = fq.imem_req_valid & fq.imem_req_ready;
    assign deq_fire  = fq.id_valid & fq.id_ready;
    assign resp_fill = rst & fq.imem_resp_valid
                     & ~redirect & (drop == '0);

    // Payload storage needs no reset; validity lives in slot_filled.
    always_ff @(posedge clk) begin
        if (req_fire)
            slot_pc[alloc_idx] <= fq.imem_req_addr;
        if (resp_fill)
            slot_inst[fill_idx] <= fq.imem_resp_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            head_ptr    <= '0;
            drop        <= '0;
            slot_filled <= '0;
        end else begin
            if (redirect) begin
                head_ptr    <= alloc_ptr;
                fill_ptr    <= alloc_ptr;
                alloc_ptr   <= alloc_ptr + ptr_t'(req_fire);
                drop        <= drop_eff;
                slot_filled <= '0;
            end else begin
                if (req_fire) begin
                    alloc_ptr              <= alloc_ptr + ONE;
                    slot_filled[alloc_idx] <= 1'b0;
                end
                if (deq_fire)
                    head_ptr <= head_ptr + ONE;
                if (fq.imem_resp_valid) begin
                    if (drop != '0) begin
                        drop <= drop - ONE;
                    end else begin
                        fill_ptr              <= fill_ptr + ONE;
                        slot_filled[fill_idx] <= 1'b1;
                    end
                end
            end
            if (req_fire)
                fetch_pc <= fq.imem_req_addr + 32'd4;
            else if (redirect)
                fetch_pc <= target;
        end
    end
endmodule
